// File: rtl/debug_dump_sequencer.sv
// Halt-time debug dump: streams PC, cycle count, registers and dirty
// data-memory words to the UART transmitter, one byte per handshake.
module debug_dump_sequencer #(
    parameter int                NB_DATA     = 32,
    parameter int                NB_REG_ADDR = 5,
    parameter int                NB_MEM_ADDR = 7,
    parameter int                NB_BYTE     = 8,
    parameter logic [NB_BYTE-1:0] END_MARK   = 8'hFF
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [NB_DATA-1:0]     i_pc,
    input  logic [NB_DATA-1:0]     i_cant_cycles,
    input  logic [NB_DATA-1:0]     i_reg_data,
    input  logic [NB_DATA-1:0]     i_mem_data,
    input  logic                   i_mem_dirty,
    input  logic                   i_tx_done,
    output logic                   o_tx_start,
    output logic [NB_BYTE-1:0]     o_tx_data,
    output logic [NB_REG_ADDR-1:0] o_addr_reg,
    output logic                   o_ctrl_read_reg,
    output logic [NB_MEM_ADDR-1:0] o_addr_mem,
    output logic                   o_ctrl_mem,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int N_WORD_BYTES = NB_DATA / NB_BYTE;
    localparam int BC_W         = $clog2(N_WORD_BYTES);
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(N_WORD_BYTES - 1);

    typedef enum logic [3:0] {
        IDLE,
        SEND_PC,
        SEND_CYC,
        REG_RD,
        REG_WAIT,
        REG_SEND,
        MEM_RD,
        MEM_WAIT,
        MEM_CHK,
        MEM_SEND_ADDR,
        MEM_SEND,
        SEND_END,
        DONE
    } state_t;

    state_t             state;
    logic [NB_DATA-1:0] word;
    logic [NB_DATA-1:0] cyc_q;
    logic [BC_W-1:0]    byte_cnt;
    logic               dirty_q;

    logic tx_ack;
    logic word_last;
    logic word_state;
    logic last_reg;
    logic last_mem;

    function automatic logic [NB_DATA-1:0] shl_byte(input logic [NB_DATA-1:0] w);
        return {w[NB_DATA-NB_BYTE-1:0], {NB_BYTE{1'b0}}};
    endfunction

    // A done tick in the same cycle as our own start pulse cannot belong to
    // the byte just launched, so it is not taken as an acknowledge.
    assign tx_ack     = i_tx_done & ~o_tx_start;
    assign word_last  = (byte_cnt == LAST_BYTE);
    assign word_state = (state == SEND_PC) || (state == SEND_CYC) ||
                        (state == REG_SEND) || (state == MEM_SEND);
    assign last_reg   = &o_addr_reg;
    assign last_mem   = &o_addr_mem;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state           <= IDLE;
            word            <= '0;
            cyc_q           <= '0;
            byte_cnt        <= '0;
            dirty_q         <= 1'b0;
            o_tx_start      <= 1'b0;
            o_tx_data       <= '0;
            o_addr_reg      <= '0;
            o_ctrl_read_reg <= 1'b0;
            o_addr_mem      <= '0;
            o_ctrl_mem      <= 1'b0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_done     <= 1'b0;
            if (word_state && tx_ack && !word_last) begin
                // next byte of the word currently on the wire
                o_tx_start <= 1'b1;
                o_tx_data  <= word[NB_DATA-1 -: NB_BYTE];
                word       <= shl_byte(word);
                byte_cnt   <= byte_cnt + 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (i_start) begin
                            cyc_q      <= i_cant_cycles;
                            o_busy     <= 1'b1;
                            o_tx_start <= 1'b1;
                            o_tx_data  <= i_pc[NB_DATA-1 -: NB_BYTE];
                            word       <= shl_byte(i_pc);
                            byte_cnt   <= '0;
                            state      <= SEND_PC;
                        end
                    end
                    SEND_PC: begin
                        if (tx_ack) begin
                            o_tx_start <= 1'b1;
                            o_tx_data  <= cyc_q[NB_DATA-1 -: NB_BYTE];
                            word       <= shl_byte(cyc_q);
                            byte_cnt   <= '0;
                            state      <= SEND_CYC;
                        end
                    end
                    SEND_CYC: begin
                        if (tx_ack) begin
                            o_addr_reg      <= '0;
                            o_ctrl_read_reg <= 1'b1;
                            state           <= REG_RD;
                        end
                    end
                    REG_RD: begin
                        state <= REG_WAIT;
                    end
                    REG_WAIT: begin
                        o_tx_start <= 1'b1;
                        o_tx_data  <= i_reg_data[NB_DATA-1 -: NB_BYTE];
                        word       <= shl_byte(i_reg_data);
                        byte_cnt   <= '0;
                        state      <= REG_SEND;
                    end
                    REG_SEND: begin
                        if (tx_ack) begin
                            if (last_reg) begin
                                o_ctrl_read_reg <= 1'b0;
                                o_addr_mem      <= '0;
                                o_ctrl_mem      <= 1'b1;
                                state           <= MEM_RD;
                            end else begin
                                o_addr_reg <= o_addr_reg + 1'b1;
                                state      <= REG_RD;
                            end
                        end
                    end
                    MEM_RD: begin
                        state <= MEM_WAIT;
                    end
                    MEM_WAIT: begin
                        word    <= i_mem_data;
                        dirty_q <= i_mem_dirty;
                        state   <= MEM_CHK;
                    end
                    MEM_CHK: begin
                        if (dirty_q) begin
                            o_tx_start <= 1'b1;
                            o_tx_data  <= NB_BYTE'(o_addr_mem);
                            state      <= MEM_SEND_ADDR;
                        end else if (last_mem) begin
                            o_ctrl_mem <= 1'b0;
                            o_tx_start <= 1'b1;
                            o_tx_data  <= END_MARK;
                            state      <= SEND_END;
                        end else begin
                            o_addr_mem <= o_addr_mem + 1'b1;
                            state      <= MEM_RD;
                        end
                    end
                    MEM_SEND_ADDR: begin
                        if (tx_ack) begin
                            o_tx_start <= 1'b1;
                            o_tx_data  <= word[NB_DATA-1 -: NB_BYTE];
                            word       <= shl_byte(word);
                            byte_cnt   <= '0;
                            state      <= MEM_SEND;
                        end
                    end
                    MEM_SEND: begin
                        if (tx_ack) begin
                            if (last_mem) begin
                                o_ctrl_mem <= 1'b0;
                                o_tx_start <= 1'b1;
                                o_tx_data  <= END_MARK;
                                state      <= SEND_END;
                            end else begin
                                o_addr_mem <= o_addr_mem + 1'b1;
                                state      <= MEM_RD;
                            end
                        end
                    end
                    SEND_END: begin
                        if (tx_ack) begin
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                            state  <= DONE;
                        end
                    end
                    DONE: begin
                        o_addr_reg <= '0;
                        o_addr_mem <= '0;
                        state      <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Bench for debug_dump_sequencer: register/memory/UART models around the
// DUT, with the expected byte stream built from the snapshot contents.
module tb_debug_dump_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [31:0] i_pc;
    logic [31:0] i_cant_cycles;
    logic [31:0] reg_data;
    logic [31:0] mem_data;
    logic        mem_dirty;
    logic        tx_done;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic [4:0]  o_addr_reg;
    logic        o_ctrl_read_reg;
    logic [6:0]  o_addr_mem;
    logic        o_ctrl_mem;
    logic        o_busy;
    logic        o_done;

    logic        uart_done;
    logic        inj_done;
    assign tx_done = uart_done | inj_done;

    always #5 clk = ~clk;

    debug_dump_sequencer dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_start        (i_start),
        .i_pc           (i_pc),
        .i_cant_cycles  (i_cant_cycles),
        .i_reg_data     (reg_data),
        .i_mem_data     (mem_data),
        .i_mem_dirty    (mem_dirty),
        .i_tx_done      (tx_done),
        .o_tx_start     (o_tx_start),
        .o_tx_data      (o_tx_data),
        .o_addr_reg     (o_addr_reg),
        .o_ctrl_read_reg(o_ctrl_read_reg),
        .o_addr_mem     (o_addr_mem),
        .o_ctrl_mem     (o_ctrl_mem),
        .o_busy         (o_busy),
        .o_done         (o_done)
    );

    logic [31:0] regs  [32];
    logic [31:0] mem   [128];
    logic        dirty [128];

    // one-clock read latency on both banks
    always @(posedge clk) begin
        reg_data  <= regs[o_addr_reg];
        mem_data  <= mem[o_addr_mem];
        mem_dirty <= dirty[o_addr_mem];
    end

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         start_cnt = 0;
    int         done_cnt = 0;
    int         stab_err = 0;
    int         ovl_err = 0;
    int         ctrl_err = 0;
    int         idle_err = 0;
    bit         slow = 1'b0;
    bit         u_busy = 1'b0;
    logic [7:0] u_byte = 8'h00;
    int         u_cnt = 0;

    function automatic int pick_delay();
        if (slow && ($urandom_range(0, 15) == 0))
            return int'($urandom_range(1, 2000));
        return int'($urandom_range(1, slow ? 6 : 3));
    endfunction

    // UART transmitter model: one byte in flight, done after a random delay
    always @(negedge clk) begin
        uart_done <= 1'b0;
        if (o_tx_start && !o_busy) idle_err <= idle_err + 1;
        if (o_ctrl_read_reg && o_ctrl_mem) ctrl_err <= ctrl_err + 1;
        if (rst) begin
            u_busy <= 1'b0;
        end else if (u_busy) begin
            if (o_tx_data !== u_byte) stab_err <= stab_err + 1;
            if (o_tx_start) ovl_err <= ovl_err + 1;
            if (u_cnt <= 1) begin
                uart_done <= 1'b1;
                u_busy    <= 1'b0;
                done_cnt  <= done_cnt + 1;
            end else begin
                u_cnt <= u_cnt - 1;
            end
        end else if (o_tx_start) begin
            u_busy    <= 1'b1;
            u_byte    <= o_tx_data;
            rx_q.push_back(o_tx_data);
            start_cnt <= start_cnt + 1;
            u_cnt     <= pick_delay();
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic void push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
    endfunction

    function automatic void build_exp(input logic [31:0] pc,
                                      input logic [31:0] cyc);
        exp_q.delete();
        push_word(pc);
        push_word(cyc);
        for (int n = 0; n < 32; n++) push_word(regs[n]);
        for (int m = 0; m < 128; m++)
            if (dirty[m]) begin
                exp_q.push_back(8'(m));
                push_word(mem[m]);
            end
        exp_q.push_back(8'hFF);
    endfunction

    function automatic void fill(input bit rand_regs, input int dirty_pct);
        for (int n = 0; n < 32; n++) regs[n] = rand_regs ? $urandom : 32'(n);
        for (int m = 0; m < 128; m++) begin
            mem[m]   = $urandom;
            dirty[m] = ($urandom_range(0, 99) < dirty_pct);
        end
    endfunction

    task automatic run_dump(input string tag, input logic [31:0] pc,
                            input logic [31:0] cyc, input bit dbl);
        int         base;
        bit         prev;
        bit         seen;
        bit         fired;
        logic [7:0] got;
        build_exp(pc, cyc);
        base          = rx_q.size();
        i_pc          = pc;
        i_cant_cycles = cyc;
        i_start       = 1'b1;
        tick();
        i_start = 1'b0;
        check({tag, "_busy_set"}, o_busy, 1);
        check({tag, "_first_start"}, o_tx_start, 1);
        check({tag, "_first_byte"}, o_tx_data, pc[31:24]);
        seen  = 1'b0;
        fired = 1'b0;
        prev  = 1'b0;
        for (int k = 0; k < 60000; k++) begin
            i_start = 1'b0;
            if (dbl && !fired && o_ctrl_read_reg) begin
                i_start = 1'b1;
                fired   = 1'b1;
            end
            prev = tx_done;
            tick();
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end
        i_start = 1'b0;
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_done_after_txdone"}, prev, 1);
        check({tag, "_busy_clear"}, o_busy, 0);
        check({tag, "_byte_count"}, rx_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
            check($sformatf("%s_byte%0d", tag, i), got, exp_q[i]);
            if (got !== exp_q[i]) break;
        end
        tick();
        check({tag, "_done_pulse"}, o_done, 0);
    endtask

    initial begin
        int sc;
        int target;
        rst           = 1'b1;
        i_start       = 1'b0;
        i_pc          = '0;
        i_cant_cycles = '0;
        inj_done      = 1'b0;
        fill(1'b0, 0);
        repeat (3) tick();
        check("rst_tx_start", o_tx_start, 0);
        check("rst_tx_data", o_tx_data, 0);
        check("rst_addr_reg", o_addr_reg, 0);
        check("rst_ctrl_reg", o_ctrl_read_reg, 0);
        check("rst_addr_mem", o_addr_mem, 0);
        check("rst_ctrl_mem", o_ctrl_mem, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            inj_done = 1'b1;
            tick();
            inj_done = 1'b0;
            tick();
        end
        check("idle_no_start", start_cnt, 0);
        check("idle_busy", o_busy, 0);
        check("idle_done", o_done, 0);

        fill(1'b0, 0);
        run_dump("clean", 32'h3, 32'h4, 1'b0);

        dirty[0]   = 1'b1;
        mem[0]     = 32'hDEADBEEF;
        dirty[127] = 1'b1;
        mem[127]   = 32'h01020304;
        run_dump("dirty_ends", 32'h3, 32'h4, 1'b0);

        fill(1'b0, 0);
        run_dump("double_start", 32'h3, 32'h4, 1'b1);

        rst     = 1'b1;
        i_start = 1'b1;
        tick();
        check("rst_vs_start_busy", o_busy, 0);
        check("rst_vs_start_tx", o_tx_start, 0);
        rst     = 1'b0;
        i_start = 1'b0;
        tick();
        check("rst_vs_start_idle", o_busy, 0);

        fill(1'b1, 10);
        target        = done_cnt + 50;
        i_pc          = $urandom;
        i_cant_cycles = $urandom;
        i_start       = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 20000 && done_cnt < target; k++) tick();
        check("abort_reached_50", done_cnt, target);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", o_busy, 0);
        check("abort_ctrl_reg", o_ctrl_read_reg, 0);
        check("abort_ctrl_mem", o_ctrl_mem, 0);
        check("abort_tx_start", o_tx_start, 0);
        sc = start_cnt;
        repeat (40) tick();
        check("abort_no_more_start", start_cnt, sc);
        check("abort_still_idle", o_busy, 0);

        run_dump("restart", $urandom, $urandom, 1'b0);

        slow = 1'b1;
        fill(1'b1, 25);
        run_dump("slow_random", $urandom, $urandom, 1'b0);
        slow = 1'b0;

        check("tx_data_stable", stab_err, 0);
        check("one_start_per_byte", ovl_err, 0);
        check("ctrl_exclusive", ctrl_err, 0);
        check("no_start_when_idle", idle_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_dump_sequencer.md
Name: debug_dump_sequencer

Overview:
- On a pipeline halt, serializes the processor debug snapshot to the host over the UART transmitter, byte by byte.
- Snapshot order: PC, cycle count, all 32 registers, then only the dirty data-memory words, then a terminator byte.
- Sits between the debug unit's halt/send decision, the register bank read port, the data-memory debug read port and the UART tx handshake.
- Sole owner of the register-bank and data-memory debug addresses while busy.

Parameters:
NB_DATA, 32, width of PC, cycle count, register and memory words
NB_REG_ADDR, 5, register-bank address width (N_REGS = 2**NB_REG_ADDR = 32)
NB_MEM_ADDR, 7, data-memory word address width (N_MEM = 2**NB_MEM_ADDR = 128)
NB_BYTE, 8, UART byte width
END_MARK, 8'hFF, terminator byte; never a valid memory address prefix since addresses are < 128

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous active-high reset
i_start  in  1  one-cycle pulse requesting a dump (halt reached)
i_pc  in  NB_DATA  program counter to report
i_cant_cycles  in  NB_DATA  executed-cycle count to report
i_reg_data  in  NB_DATA  register-bank read data
i_mem_data  in  NB_DATA  data-memory read data
i_mem_dirty  in  1  dirty flag of the word at o_addr_mem, same timing as i_mem_data
i_tx_done  in  1  UART tx done tick, one cycle per byte
o_tx_start  out  1  one-cycle pulse to start a UART byte
o_tx_data  out  NB_BYTE  byte to transmit
o_addr_reg  out  NB_REG_ADDR  register-bank read address
o_ctrl_read_reg  out  1  high while the sequencer owns the register read port
o_addr_mem  out  NB_MEM_ADDR  data-memory read address
o_ctrl_mem  out  1  high while the sequencer owns the memory debug port
o_busy  out  1  high from the cycle after i_start until o_done
o_done  out  1  one-cycle pulse after the terminator byte's i_tx_done

Behaviour:
- Reset: all outputs 0, state IDLE, internal counters 0.
- Reset mid-dump aborts immediately to IDLE. No further o_tx_start is issued.
- States: IDLE, SEND_PC, SEND_CYC, REG_RD, REG_WAIT, REG_SEND, MEM_RD, MEM_WAIT, MEM_CHK, MEM_SEND_ADDR, MEM_SEND, SEND_END, DONE.
- IDLE: on i_start, latch i_pc and i_cant_cycles, set o_busy, go to SEND_PC.
- i_start while busy is ignored. i_tx_done outside a byte wait is ignored.
- Byte sender (shared by all SEND states):
  - Drive o_tx_data and pulse o_tx_start for one cycle.
  - Hold o_tx_data stable until i_tx_done.
  - The next o_tx_start comes no earlier than the cycle after i_tx_done.
- Words are sent MSB byte first, 4 bytes each.
- First o_tx_start occurs the cycle after i_start is sampled.
- REG_RD/REG_WAIT: present o_addr_reg = n. Read data is valid one clock later; latch it in REG_WAIT, then REG_SEND.
- Registers: n runs 0..31. After n = 31, go to MEM_RD with m = 0.
- o_ctrl_read_reg is high in REG_RD through the last REG_SEND.
- MEM_RD/MEM_WAIT: same one-clock read latency as the register bank. Latch i_mem_data and i_mem_dirty together.
- MEM_CHK:
  - Dirty: MEM_SEND_ADDR sends byte {1'b0, m}, then MEM_SEND sends the 4 data bytes.
  - Clean: skip the word and send no bytes.
- Memory walk: m runs 0..127 with no wrap. After m = 127, go to SEND_END.
- o_ctrl_mem is high in MEM_RD through the last MEM_SEND or MEM_CHK.
- SEND_END: send END_MARK. On its i_tx_done go to DONE.
- DONE: pulse o_done, clear o_busy, return to IDLE.
- Byte count = 8 + 128 + 5·(dirty words) + 1. Minimum 137 bytes, maximum 777 bytes.
- Simultaneous i_reset and i_start: reset wins.

Test Plan:
- Reset then idle, i_tx_done pulses injected -> all outputs stay 0, no o_tx_start.
- i_pc=0x00000003, i_cant_cycles=4, regs r[n]=n, no dirty words, UART loopback model:
  - Host receives 00 00 00 03, 00 00 00 04, then 00 00 00 00 … 00 00 00 1F, then FF.
  - 137 bytes total; o_done one cycle after the last tx_done.
- Dirty words at addresses 0 (0xDEADBEEF) and 127 (0x01020304) -> after the registers: 00 DE AD BE EF 7F 01 02 03 04 FF; 147 bytes total.
- Second i_start pulse during the register phase -> ignored; byte stream identical to the single-start case.
- i_reset asserted after the 50th byte's tx_done -> next cycle o_busy=0, o_ctrl_read_reg=0, o_ctrl_mem=0, no further o_tx_start. A new i_start restarts from the PC bytes.
- UART model delays i_tx_done by a random 1..2000 cycles per byte -> o_tx_data stable between each o_tx_start and its done, exactly one o_tx_start per byte, ordering unchanged.
